rand_check: RTL and testbench

//  Self-synchronising checker for the xorshift32 (<<13, >>17, <<5) pseudo-random stream.

---
 rtl/rand_check_if.sv | 14 +
 rtl/rand_check.sv | 131 +++++++++++++
 tb/tb_rand_check.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_check_if.sv
// Receive-side word link into the xorshift32 checker: valid/ready handshake plus data.
// `DATA_W sets the data width (32 for xorshift32).
`ifndef DATA_W
`define DATA_W 32
`endif

interface rand_check_if;
    logic               in_valid;
    logic [`DATA_W-1:0] in_data;
    logic               in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/rand_check.sv
// Self-synchronising xorshift32 (<<13, >>17, <<5) stream checker with saturating error/word counters.
// Define RAND_CHK_RESYNC_EN to leave LOST automatically after one cycle; otherwise LOST is sticky.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_HUNT   | waiting for a non-zero word to seed the predictor
// S_LOCKED | predicting each word, counting words and mismatches
// S_LOST   | too many consecutive misses; stalls upstream unless resync
module rand_check #(
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    rand_check_if.slave      lnk,
    output logic             locked,
    output logic             lost,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {S_HUNT, S_LOCKED, S_LOST} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pred_q, pred_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic               locked_q, locked_d;
    logic               lost_q, lost_d;
    logic               ready_q, ready_d;
    logic               xfer;

    function automatic logic [31:0] xs_next(input logic [31:0] x);
        logic [31:0] x1, x2;
        x1 = x ^ (x << 13);
        x2 = x1 ^ (x1 >> 17);
        return x2 ^ (x2 << 5);
    endfunction

    assign xfer = lnk.in_valid & ready_q;

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;
        err_pulse_d = 1'b0;
        if (clr) begin
            state_d    = S_HUNT;
            miss_d     = '0;
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                S_HUNT: begin
                    // zero is a fixed point of xorshift and can never seed a useful prediction
                    if (xfer && lnk.in_data != '0) begin
                        pred_d  = xs_next(lnk.in_data);
                        miss_d  = '0;
                        state_d = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (xfer) begin
                        if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
                        if (lnk.in_data == pred_q) begin
                            pred_d = xs_next(lnk.in_data);
                            miss_d = '0;
                        end else begin
                            // advance from the prediction so one corrupted word costs one error
                            err_pulse_d = 1'b1;
                            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                            pred_d = xs_next(pred_q);
                            miss_d = miss_q + 1'b1;
                            if (miss_q + 1'b1 == MISS_W'(LOSS_THRESH)) state_d = S_LOST;
                        end
                    end
                end
                S_LOST: begin
`ifdef RAND_CHK_RESYNC_EN
                    state_d = S_HUNT;
                    miss_d  = '0;
`else
                    state_d = S_LOST;
`endif
                end
                default: state_d = S_HUNT;
            endcase
        end
        locked_d = (state_d == S_LOCKED);
        lost_d   = (state_d == S_LOST);
        ready_d  = (state_d != S_LOST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            pred_q      <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            lost_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            lost_q      <= lost_d;
            ready_q     <= ready_d;
        end
    end

    assign lnk.in_ready = ready_q;
    assign locked       = locked_q;
    assign lost         = lost_q;
    assign err_pulse    = err_pulse_q;
    assign err_cnt      = err_cnt_q;
    assign word_cnt     = word_cnt_q;
endmodule

// File: tb/tb_rand_check.sv
// Bench for rand_check: golden xorshift32 streams with corruption, gaps and clears,
// checked against a word-level reference model; a second instance covers counter saturation.
module tb_rand_check;
    localparam int          LOSS_THRESH = 4;
    localparam int          CNT_W       = 16;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;
    localparam logic [31:0] SEED        = 32'hEBADD4A9;
    localparam logic [31:0] JUNK        = 32'h12345678;

    logic             clk = 1'b0;
    logic             rst_n, clr, clr4;
    logic             locked, lost, err_pulse;
    logic [CNT_W-1:0] err_cnt, word_cnt;
    logic             locked4, lost4, err_pulse4;
    logic [3:0]       err_cnt4, word_cnt4;

    rand_check_if ifc ();
    rand_check_if ifc4 ();

    rand_check #(.LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .lnk(ifc),
        .locked(locked), .lost(lost), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    rand_check #(.LOSS_THRESH(32), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr4), .lnk(ifc4),
        .locked(locked4), .lost(lost4), .err_pulse(err_pulse4),
        .err_cnt(err_cnt4), .word_cnt(word_cnt4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum {M_HUNT, M_LOCKED, M_LOST} mst_t;
    mst_t        m_st;
    logic [31:0] m_pred;
    int          m_miss, m_err, m_words;
    bit          m_pulse;
    logic [31:0] gold[$];

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic void model_reset();
        m_st = M_HUNT; m_pred = '0; m_miss = 0; m_err = 0; m_words = 0; m_pulse = 0;
    endfunction

    // Word-level behaviour of the checker for one clock edge.
    function automatic void model_step(input bit x, input logic [31:0] w, input bit c);
        m_pulse = 0;
        if (c) begin
            m_st = M_HUNT; m_miss = 0; m_err = 0; m_words = 0;
        end else if (m_st == M_LOST) begin
`ifdef RAND_CHK_RESYNC_EN
            m_st = M_HUNT;
`endif
        end else if (x && m_st == M_HUNT) begin
            if (w != 0) begin m_pred = xs(w); m_miss = 0; m_st = M_LOCKED; end
        end else if (x) begin
            m_words = (m_words < CNT_MAX) ? m_words + 1 : CNT_MAX;
            if (w == m_pred) begin
                m_pred = xs(w); m_miss = 0;
            end else begin
                m_pulse = 1;
                m_err   = (m_err < CNT_MAX) ? m_err + 1 : CNT_MAX;
                m_pred  = xs(m_pred);
                m_miss++;
                if (m_miss >= LOSS_THRESH) m_st = M_LOST;
            end
        end
    endfunction

    // Advance one clock from a negedge to the next, updating the model with what happens at the edge.
    task automatic cycle();
        bit          x;
        logic [31:0] w;
        bit          c;
        x = ifc.in_valid && ifc.in_ready;
        w = ifc.in_data;
        c = clr;
        @(posedge clk);
        model_step(x, w, c);
        @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1; ifc.in_valid = 1'b0;
        cycle();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; clr4 = 1'b0;
        ifc.in_valid = 1'b0;  ifc.in_data = '0;
        ifc4.in_valid = 1'b0; ifc4.in_data = '0;
        repeat (3) @(negedge clk);
        model_reset();
        n_cmp++;
        if ({locked, lost, err_pulse, ifc.in_ready} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {locked, lost, err_pulse, ifc.in_ready});
        end
        n_cmp++;
        if (err_cnt !== '0 || word_cnt !== '0) begin
            n_bad++; $display("FAIL reset_cnt: got err=%0d words=%0d want 0/0", err_cnt, word_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ifc.in_ready !== 1'b1 || ifc4.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_reset: got %b%b want 11", ifc.in_ready, ifc4.in_ready);
        end
    endtask

    task automatic test_golden_stream();
        for (int i = 0; i < 1000; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = gold[i];
            cycle();
            n_cmp++;
            if ({locked, lost, err_pulse, ifc.in_ready} !== {m_st == M_LOCKED, m_st == M_LOST, m_pulse, m_st != M_LOST}) begin
                n_bad++; $display("FAIL golden_flags word %0d: got %b", i, {locked, lost, err_pulse, ifc.in_ready});
            end
        end
        ifc.in_valid = 1'b0;
        n_cmp++;
        if (locked !== 1'b1 || lost !== 1'b0) begin
            n_bad++; $display("FAIL golden_lock: got locked=%b lost=%b want 1/0", locked, lost);
        end
        n_cmp++;
        if (err_cnt !== 16'd0 || word_cnt !== 16'd999) begin
            n_bad++; $display("FAIL golden_cnt: got err=%0d words=%0d want 0/999", err_cnt, word_cnt);
        end
    endtask

    task automatic test_single_error();
        int pulses = 0;
        do_clr();
        for (int i = 0; i < 30; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = (i == 10) ? (gold[i] ^ 32'h1) : gold[i];
            cycle();
            if (err_pulse === 1'b1) pulses++;
            n_cmp++;
            if ({locked, lost, err_pulse} !== {m_st == M_LOCKED, m_st == M_LOST, m_pulse}) begin
                n_bad++; $display("FAIL single_err_flags word %0d: got %b", i, {locked, lost, err_pulse});
            end
        end
        ifc.in_valid = 1'b0;
        n_cmp++;
        if (pulses != 1 || err_cnt !== 16'd1 || locked !== 1'b1 || word_cnt !== 16'd29) begin
            n_bad++; $display("FAIL single_err_total: got pulses=%0d err=%0d locked=%b words=%0d want 1/1/1/29",
                              pulses, err_cnt, locked, word_cnt);
        end
    endtask

    task automatic test_loss();
        do_clr();
        for (int i = 0; i < 9; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = (i < 5) ? gold[i] : JUNK;
            cycle();
            n_cmp++;
            if ({locked, lost, err_pulse, ifc.in_ready} !== {m_st == M_LOCKED, m_st == M_LOST, m_pulse, m_st != M_LOST}) begin
                n_bad++; $display("FAIL loss_flags word %0d: got %b", i, {locked, lost, err_pulse, ifc.in_ready});
            end
        end
        ifc.in_valid = 1'b0;
        n_cmp++;
        if (err_cnt !== 16'd4 || lost !== 1'b1 || locked !== 1'b0) begin
            n_bad++; $display("FAIL loss_enter: got err=%0d lost=%b locked=%b want 4/1/0", err_cnt, lost, locked);
        end
`ifdef RAND_CHK_RESYNC_EN
        cycle();
        n_cmp++;
        if ({locked, lost, ifc.in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL resync_hunt: got %b want 001", {locked, lost, ifc.in_ready});
        end
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = gold[i];
            cycle();
        end
        ifc.in_valid = 1'b0;
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd4 || err_pulse !== 1'b0) begin
            n_bad++; $display("FAIL resync_relock: got locked=%b err=%0d pulse=%b want 1/4/0", locked, err_cnt, err_pulse);
        end
`else
        ifc.in_valid = 1'b1; ifc.in_data = gold[0];
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if (ifc.in_ready !== 1'b0 || lost !== 1'b1 || err_cnt !== 16'd4) begin
                n_bad++; $display("FAIL lost_sticky cyc %0d: got ready=%b lost=%b err=%0d want 0/1/4",
                                  i, ifc.in_ready, lost, err_cnt);
            end
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0; ifc.in_valid = 1'b0;
        n_cmp++;
        if ({locked, lost, ifc.in_ready} !== 3'b001 || err_cnt !== 16'd0) begin
            n_bad++; $display("FAIL lost_clr: got flags=%b err=%0d want 001/0", {locked, lost, ifc.in_ready}, err_cnt);
        end
`endif
    endtask

    task automatic test_zero_hunt();
        do_clr();
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 32'h0;
            cycle();
            n_cmp++;
            if ({locked, lost, ifc.in_ready} !== 3'b001 || word_cnt !== 16'd0) begin
                n_bad++; $display("FAIL zero_hunt %0d: got flags=%b words=%0d want 001/0", i, {locked, lost, ifc.in_ready}, word_cnt);
            end
        end
        ifc.in_data = SEED;
        cycle();
        ifc.in_valid = 1'b0;
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd0) begin
            n_bad++; $display("FAIL zero_then_seed: got locked=%b err=%0d want 1/0", locked, err_cnt);
        end
    endtask

    task automatic test_gaps();
        int i = 0;
        int cyc = 0;
        do_clr();
        while (i < 500 && cyc < 5000) begin
            if ($urandom_range(0, 99) < 30) begin
                ifc.in_valid = 1'b0; ifc.in_data = $urandom;
            end else begin
                ifc.in_valid = 1'b1; ifc.in_data = gold[i];
                if (ifc.in_ready) i++;
            end
            cycle();
            cyc++;
            n_cmp++;
            if ({locked, lost, err_pulse} !== {m_st == M_LOCKED, m_st == M_LOST, m_pulse}) begin
                n_bad++; $display("FAIL gaps_flags cyc %0d: got %b", cyc, {locked, lost, err_pulse});
            end
        end
        ifc.in_valid = 1'b0;
        n_cmp++;
        if (i != 500 || err_cnt !== 16'd0 || word_cnt !== 16'd499) begin
            n_bad++; $display("FAIL gaps_total: got sent=%0d err=%0d words=%0d want 500/0/499", i, err_cnt, word_cnt);
        end
    endtask

    task automatic test_clr();
        do_clr();
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = (i < 3) ? gold[i] : JUNK;
            cycle();
        end
        n_cmp++;
        if (err_cnt !== 16'd1 || err_pulse !== 1'b1) begin
            n_bad++; $display("FAIL clr_pre: got err=%0d pulse=%b want 1/1", err_cnt, err_pulse);
        end
        ifc.in_data = 32'h0BADBEEF; clr = 1'b1;
        cycle();
        clr = 1'b0; ifc.in_valid = 1'b0;
        n_cmp++;
        if ({locked, lost, err_pulse, ifc.in_ready} !== 4'b0001 || err_cnt !== 16'd0 || word_cnt !== 16'd0) begin
            n_bad++; $display("FAIL clr_wins: got flags=%b err=%0d words=%0d want 0001/0/0",
                              {locked, lost, err_pulse, ifc.in_ready}, err_cnt, word_cnt);
        end

        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        ifc4.in_valid = 1'b1; ifc4.in_data = SEED;
        @(negedge clk);
        n_cmp++;
        if (locked4 !== 1'b1) begin
            n_bad++; $display("FAIL sat_lock: got locked=%b want 1", locked4);
        end
        ifc4.in_data = JUNK;
        for (int k = 1; k <= 20; k++) begin
            if (ifc4.in_ready !== 1'b1) begin
                n_cmp++; n_bad++; $display("FAIL sat_ready word %0d: got %b want 1", k, ifc4.in_ready);
            end
            @(negedge clk);
            if (k == 10) begin
                n_cmp++;
                if (err_cnt4 !== 4'd10) begin
                    n_bad++; $display("FAIL sat_mid: got err=%0d want 10", err_cnt4);
                end
            end
        end
        ifc4.in_valid = 1'b0;
        n_cmp++;
        if (err_cnt4 !== 4'd15 || word_cnt4 !== 4'd15 || lost4 !== 1'b0) begin
            n_bad++; $display("FAIL sat_hold: got err=%0d words=%0d lost=%b want 15/15/0", err_cnt4, word_cnt4, lost4);
        end
    endtask

    initial begin
        gold.push_back(SEED);
        for (int i = 1; i < 1100; i++) gold.push_back(xs(gold[i-1]));
        test_reset();
        test_golden_stream();
        test_single_error();
        test_loss();
        test_zero_hunt();
        test_gaps();
        test_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
